// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: baud tick divider, valid/ready TX, 16x-oversampled RX.
// Define UART_PARITY_EN to add one parity bit per frame (PARITY_ODD selects odd/even).
module uart_core_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_frame_err,
  output logic                  rx_parity_err
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_WIDTH + 1);
  localparam bit PAR_ODD = (PARITY_ODD != 0);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick;

  state_t                tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_out_q, tx_out_d;
  logic                  tx_ev;

  logic                  sync1_q, sync2_q, prev_q;
  state_t                rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_par_q, rx_par_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_ferr_q, rx_ferr_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ev;

  assign tick     = (div_cnt_q == '0);
  assign div_cnt_d = tick ? DW'(DIV - 1) : div_cnt_q - DW'(1);

  // A bit boundary is the tick on which the per-bit down-counter is at terminal count.
  assign tx_ev    = tick && (tx_cnt_q == '0);
  assign tx_ready = (tx_state_q == S_IDLE) && enable && !rst;
  assign tx_busy  = (tx_state_q != S_IDLE);
  assign tx_out   = tx_out_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_out_d   = tx_out_q;
    if (tx_state_q != S_IDLE && tick)
      tx_cnt_d = (tx_cnt_q == '0) ? CW'(OVERSAMPLE - 1) : tx_cnt_q - CW'(1);
    case (tx_state_q)
      S_IDLE: begin
        tx_out_d = 1'b1;
        if (tx_valid && tx_ready) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
          tx_cnt_d   = CW'(OVERSAMPLE - 1);
          tx_out_d   = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: if (tx_ev) begin
        tx_out_d   = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = BW'(DATA_WIDTH - 1);
        tx_state_d = S_DATA;
      end
      S_DATA: if (tx_ev) begin
        if (tx_bit_q == '0) begin
          if (PAR_EN) begin
            tx_out_d   = tx_par_q;
            tx_state_d = S_PARITY;
          end else begin
            tx_out_d   = 1'b1;
            tx_bit_d   = BW'(STOP_BITS - 1);
            tx_state_d = S_STOP;
          end
        end else begin
          tx_out_d   = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q - BW'(1);
        end
      end
      S_PARITY: if (tx_ev) begin
        tx_out_d   = 1'b1;
        tx_bit_d   = BW'(STOP_BITS - 1);
        tx_state_d = S_STOP;
      end
      S_STOP: if (tx_ev) begin
        if (tx_bit_q == '0) tx_state_d = S_IDLE;
        else                tx_bit_d   = tx_bit_q - BW'(1);
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign rx_ev         = tick && (rx_cnt_q == '0);
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_par_d   = rx_par_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = rx_ferr_q;
    rx_perr_d  = rx_perr_q;
    if (rx_state_q != S_IDLE && tick)
      rx_cnt_d = (rx_cnt_q == '0) ? CW'(OVERSAMPLE - 1) : rx_cnt_q - CW'(1);
    case (rx_state_q)
      S_IDLE: if (enable && prev_q && !sync2_q) begin
        // First sample lands mid start bit; later ones are a full bit apart.
        rx_cnt_d   = CW'(OVERSAMPLE / 2 - 1);
        rx_state_d = S_START;
      end
      S_START: if (rx_ev) begin
        rx_bit_d   = BW'(DATA_WIDTH - 1);
        rx_state_d = sync2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_ev) begin
        rx_shift_d = {sync2_q, rx_shift_q[DATA_WIDTH-1:1]};
        if (rx_bit_q == '0) rx_state_d = PAR_EN ? S_PARITY : S_STOP;
        else                rx_bit_d   = rx_bit_q - BW'(1);
      end
      S_PARITY: if (rx_ev) begin
        rx_par_d   = sync2_q;
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_ev) begin
        rx_data_d  = rx_shift_q;
        rx_ferr_d  = !sync2_q;
        rx_perr_d  = PAR_EN ? (rx_par_q != ((^rx_shift_q) ^ PAR_ODD)) : 1'b0;
        rx_valid_d = 1'b1;
        rx_state_d = S_IDLE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= DW'(DIV - 1);
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
      sync1_q    <= rx_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_par_q   <= rx_par_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param at DIV=10, 160 clk per bit.
module tb_uart_core_param;
  localparam int BIT = 160;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
  localparam int NV  = 7;
`else
  localparam int PAR = 0;
  localparam int NV  = 5;
`endif

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, tx_valid = 1'b0;
  logic       rx_drv = 1'b1, loop_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_out, tx_busy, rx_in, rx_valid, rx_frame_err, rx_parity_err;
  logic [7:0] rx_data;

  assign rx_in = loop_en ? tx_out : rx_drv;

  uart_core_param #(.DATA_WIDTH(8), .CLK_FREQ(1_600_000), .BAUD_RATE(10_000),
                    .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rx_cnt = 0, cap_cyc = 0, rdy_run = 0, rdy_last = 0, hi_run = 0;
  logic [7:0] cap_d = 8'h00;
  logic cap_fe = 1'b0, cap_pe = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      cap_d   <= rx_data;
      cap_fe  <= rx_frame_err;
      cap_pe  <= rx_parity_err;
      cap_cyc <= cyc;
    end
    if (!tx_ready) rdy_run <= rdy_run + 1;
    else if (rdy_run != 0) begin
      rdy_last <= rdy_run;
      rdy_run  <= 0;
    end
    if (tx_out) hi_run <= hi_run + 1;
    else        hi_run <= 0;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input logic pflip);
    rx_drv = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT) @(posedge clk);
    end
    if (PAR != 0) begin
      rx_drv = (^d) ^ pflip;
      repeat (BIT) @(posedge clk);
    end
    rx_drv = stop;
    repeat (BIT) @(posedge clk);
    rx_drv = 1'b1;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // Must be called on the first sample where the start bit is low.
  task automatic grab_tx(output logic [7:0] d, output logic stopv, output logic parv);
    int idx = 0;
    parv = 1'b0;
    for (int k = 1; k <= 9 + PAR; k++) begin
      while (idx < BIT * k + BIT / 2) begin
        @(posedge clk);
        #1;
        idx++;
      end
      if (k <= 8)          d[k-1] = tx_out;
      else if (k == 9 + PAR) stopv = tx_out;
      else                 parv = tx_out;
    end
  endtask

  task automatic wait_tx_low(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!tx_out) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_ready_back"}, tx_ready, 1);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       pflip;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } rx_vec_t;

  rx_vec_t vecs[NV];

  logic [7:0] d1, d2;
  logic sv, pv, ok;
  int base, f_cyc, hi;

  initial begin
    vecs[0] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
`ifdef UART_PARITY_EN
    vecs[5] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
`endif

    tick_n(5);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", rx_frame_err, 0);
    chk("rst_parity_err", rx_parity_err, 0);
    rst = 1'b0;
    enable = 1'b1;
    tick_n(20);
    chk("idle_ready", tx_ready, 1);

    // tx of 0xA5: bit pattern and ready-low duration
    start_tx(8'hA5);
    chk("t1_start_low", tx_out, 0);
    chk("t1_ready_drop", tx_ready, 0);
    chk("t1_busy", tx_busy, 1);
    grab_tx(d1, sv, pv);
    chk("t1_data", d1, 8'hA5);
    chk("t1_stop", sv, 1);
    wait_ready("t1");
    tick_n(1);
    chk_rng("t1_ready_low", rdy_last, 1591 + PAR * BIT, 1600 + PAR * BIT);
    tick_n(50);

    // loopback 0xA5
    loop_en = 1'b1;
    base = rx_cnt;
    start_tx(8'hA5);
    f_cyc = cyc;
    tick_n((11 + PAR) * BIT);
    chk("t2_count", rx_cnt, base + 1);
    chk("t2_data", cap_d, 8'hA5);
    chk("t2_frame_err", cap_fe, 0);
    chk("t2_parity_err", cap_pe, 0);
    chk_rng("t2_latency", cap_cyc - f_cyc, 1510 + PAR * BIT, 1530 + PAR * BIT);
    loop_en = 1'b0;
    tick_n(50);

    // 40-clk glitch must not start a frame
    base = rx_cnt;
    rx_drv = 1'b0;
    tick_n(40);
    rx_drv = 1'b1;
    tick_n(400);
    chk("t3_glitch_no_valid", rx_cnt, base);

    for (int i = 0; i < NV; i++) begin
      base = rx_cnt;
      send_rx(vecs[i].d, vecs[i].stop, vecs[i].pflip);
      chk($sformatf("vec%0d_count", i), rx_cnt, base + 1);
      chk($sformatf("vec%0d_data", i), cap_d, vecs[i].exp_d);
      chk($sformatf("vec%0d_frame_err", i), cap_fe, vecs[i].exp_fe);
      chk($sformatf("vec%0d_parity_err", i), cap_pe, vecs[i].exp_pe);
    end

    // enable=0 blocks both directions
    enable = 1'b0;
    tick_n(2);
    base = rx_cnt;
    chk("en0_ready", tx_ready, 0);
    tx_data  = 8'h33;
    tx_valid = 1'b1;
    tick_n(5);
    tx_valid = 1'b0;
    chk("en0_no_tx", tx_busy, 0);
    send_rx(8'h5A, 1'b1, 1'b0);
    chk("en0_no_rx", rx_cnt, base);
    enable = 1'b1;
    tick_n(20);

    // back-to-back frames with tx_valid held
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    tick_n(1);
    tx_data = 8'h22;
    chk("t5_first_start", tx_out, 0);
    grab_tx(d1, sv, pv);
    chk("t5_first_data", d1, 8'h11);
    wait_tx_low(ok);
    hi = hi_run;
    tx_valid = 1'b0;
    chk("t5_second_started", ok, 1);
    chk("t5_stop_run", hi, BIT + 1);
    grab_tx(d2, sv, pv);
    chk("t5_second_data", d2, 8'h22);
    chk("t5_second_stop", sv, 1);
    wait_ready("t5");
    tick_n(20);

    // reset mid-frame
    start_tx(8'hFF);
    tick_n(500);
    rst = 1'b1;
    tick_n(1);
    chk("t6_rst_tx_out", tx_out, 1);
    chk("t6_rst_busy", tx_busy, 0);
    chk("t6_rst_ready", tx_ready, 0);
    rst = 1'b0;
    tick_n(1);
    chk("t6_ready_after", tx_ready, 1);
    chk("t6_tx_out_after", tx_out, 1);
    rst = 1'b1;
    tx_data  = 8'h44;
    tx_valid = 1'b1;
    tick_n(1);
    rst = 1'b0;
    tx_valid = 1'b0;
    tick_n(2);
    chk("t6_hs_in_rst_ignored", tx_busy, 0);
    tick_n(20);

`ifdef UART_PARITY_EN
    start_tx(8'h07);
    grab_tx(d1, sv, pv);
    chk("par_tx_data", d1, 8'h07);
    chk("par_tx_bit", pv, 1);
    chk("par_tx_stop", sv, 1);
    wait_ready("par");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
